// File: rtl/lab4_prod_accum.sv
// ----------------------------------------------------------------------------
// lab4_prod_accum
//
// Accumulates COUNT unsigned 8-bit products from the 5x3 multiplier into an
// ACC_W-bit running sum. The block result is then presented with a
// valid/ack handshake. This lets one combinational multiplier be time-shared
// to build a dot product of COUNT terms.
//
// Parameters:
//   COUNT  products per block (1..15)
//   ACC_W  accumulator width in bits (8..16)
//
// Build option:
//   LAB4_ACC_SATURATE_EN  when defined, a carry out of ACC_W clamps the sum
//                         to all-ones for the rest of the block instead of
//                         wrapping. The handshake is unchanged.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   in_start     begin/restart a block (clears sum, count, overflow)
//   in_valid     in_m carries a product this cycle
//   in_m         8-bit unsigned product
//   in_ack       consumer has taken out_sum
//   out_ready    block accepts products (ACCUM state)
//   out_sum      accumulator register
//   out_valid    out_sum holds a completed block (HOLD state)
//   out_overflow sticky carry-out flag for the current block
//   out_count    products accepted in the current block
// ----------------------------------------------------------------------------
module lab4_prod_accum #(
    parameter int COUNT = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_start,
    input  logic             in_valid,
    input  logic [7:0]       in_m,
    input  logic             in_ack,
    output logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_valid,
    output logic             out_overflow,
    output logic [3:0]       out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(COUNT - 1);

    state_t           state_r;
    state_t           state_s;
    logic             clear_s;
    logic             accept_s;
    logic [ACC_W:0]   add_s;
    logic [ACC_W-1:0] sum_next_s;

    // Next-state decode; start takes priority over a coincident product.
    always_comb begin
        state_s  = state_r;
        clear_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_start) begin
                    clear_s = 1'b1;
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_start) begin
                    clear_s = 1'b1;
                    state_s = ACCUM;
                end else if (in_valid) begin
                    accept_s = 1'b1;
                    if (out_count == LAST_IDX) begin
                        state_s = HOLD;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                // Start doubles as an acknowledge and skips IDLE.
                if (in_start) begin
                    clear_s = 1'b1;
                    state_s = ACCUM;
                end else if (in_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One-bit-wider add so the carry out of ACC_W is observable.
    always_comb begin
        add_s = {1'b0, out_sum} + {{(ACC_W - 7){1'b0}}, in_m};
`ifdef LAB4_ACC_SATURATE_EN
        // Once overflowed, the sum stays pinned at full scale for the block.
        if (add_s[ACC_W] || out_overflow) begin
            sum_next_s = {ACC_W{1'b1}};
        end else begin
            sum_next_s = add_s[ACC_W-1:0];
        end
`else
        sum_next_s = add_s[ACC_W-1:0];
`endif
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            out_ready    <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= {ACC_W{1'b0}};
            out_count    <= 4'd0;
            out_overflow <= 1'b0;
        end else begin
            state_r   <= state_s;
            out_ready <= (state_s == ACCUM);
            out_valid <= (state_s == HOLD);
            if (clear_s) begin
                out_sum      <= {ACC_W{1'b0}};
                out_count    <= 4'd0;
                out_overflow <= 1'b0;
            end else if (accept_s) begin
                out_sum      <= sum_next_s;
                out_count    <= out_count + 4'd1;
                out_overflow <= out_overflow | add_s[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_lab4_prod_accum.sv
// ----------------------------------------------------------------------------
// Directed testbench for lab4_prod_accum. Three instances share stimulus:
// default parameters, ACC_W=8 (overflow behaviour) and COUNT=1.
// Inputs change on the falling edge. Outputs are checked on the falling
// edge, so they reflect every rising edge before it.
// ----------------------------------------------------------------------------
module tb_lab4_prod_accum;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_m = 8'd0;
    logic       in_ack = 1'b0;

    logic       out_ready, out_valid, out_overflow;
    logic [9:0] out_sum;
    logic [3:0] out_count;

    logic       ready8, valid8, ovf8;
    logic [7:0] sum8;
    logic [3:0] count8;

    logic       ready1, valid1, ovf1;
    logic [9:0] sum1;
    logic [3:0] count1;

    int n_checks = 0;
    int n_fail = 0;

`ifdef LAB4_ACC_SATURATE_EN
    localparam logic [7:0] EXP_SUM8 = 8'd255;
`else
    localparam logic [7:0] EXP_SUM8 = 8'd100;
`endif

    always #5 clk = ~clk;

    lab4_prod_accum u_dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_valid(in_valid),
        .in_m(in_m), .in_ack(in_ack), .out_ready(out_ready), .out_sum(out_sum),
        .out_valid(out_valid), .out_overflow(out_overflow), .out_count(out_count)
    );

    lab4_prod_accum #(.COUNT(4), .ACC_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_start(in_start), .in_valid(in_valid),
        .in_m(in_m), .in_ack(in_ack), .out_ready(ready8), .out_sum(sum8),
        .out_valid(valid8), .out_overflow(ovf8), .out_count(count8)
    );

    lab4_prod_accum #(.COUNT(1), .ACC_W(10)) u_dut1 (
        .clk(clk), .reset(reset), .in_start(in_start), .in_valid(in_valid),
        .in_m(in_m), .in_ack(in_ack), .out_ready(ready1), .out_sum(sum1),
        .out_valid(valid1), .out_overflow(ovf1), .out_count(count1)
    );

    // Wait for the falling edge, then drive one cycle of inputs.
    task automatic cyc(input logic s, input logic v, input logic [7:0] m, input logic a);
        @(negedge clk);
        in_start = s;
        in_valid = v;
        in_m     = m;
        in_ack   = a;
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (out_sum !== 10'd0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", out_sum); end
        n_checks++; if ({out_ready, out_valid, out_overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {out_ready, out_valid, out_overflow}); end
        n_checks++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'd33, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if ({out_ready, out_sum} !== 11'd0) begin n_fail++; $display("FAIL idle_ignore: got ready=%b sum=%0d expected 0/0", out_ready, out_sum); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 8'd217, 1'b0);
        n_checks++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", out_ready); end
        cyc(1'b0, 1'b1, 8'd217, 1'b0);
        cyc(1'b0, 1'b1, 8'd217, 1'b0);
        cyc(1'b0, 1'b1, 8'd217, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || out_count !== 4'd3) begin n_fail++; $display("FAIL b2b_early: got valid=%b count=%0d expected 0/3", out_valid, out_count); end
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got valid=%b ready=%b expected 1/0", out_valid, out_ready); end
        n_checks++; if (out_sum !== 10'd868) begin n_fail++; $display("FAIL b2b_sum: got %0d expected 868", out_sum); end
        n_checks++; if (out_count !== 4'd4 || out_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt_ovf: got %0d/%b expected 4/0", out_count, out_overflow); end
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || out_sum !== 10'd868) begin n_fail++; $display("FAIL b2b_ack: got valid=%b sum=%0d expected 0/868", out_valid, out_sum); end
    endtask

    task automatic test_bubbles();
        logic [7:0] prods [4];
        logic [9:0] exp_sum;
        prods = '{8'd10, 8'd20, 8'd30, 8'd40};
        exp_sum = 10'd0;
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, prods[i], 1'b0);
            exp_sum = exp_sum + {2'b00, prods[i]};
            for (int b = 0; b < 2; b++) begin
                cyc(1'b0, 1'b0, 8'd0, 1'b0);
                n_checks++; if (out_sum !== exp_sum || out_valid !== (i == 3)) begin n_fail++; $display("FAIL bubble_%0d_%0d: got sum=%0d valid=%b expected %0d/%b", i, b, out_sum, out_valid, exp_sum, (i == 3)); end
            end
        end
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_overflow();
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'd217, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (sum8 !== EXP_SUM8) begin n_fail++; $display("FAIL ovf_sum8: got %0d expected %0d", sum8, EXP_SUM8); end
        n_checks++; if (ovf8 !== 1'b1 || valid8 !== 1'b1 || count8 !== 4'd4) begin n_fail++; $display("FAIL ovf_flags8: got ovf=%b valid=%b count=%0d expected 1/1/4", ovf8, valid8, count8); end
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_restart();
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 8'd5, 1'b0);
        cyc(1'b0, 1'b1, 8'd6, 1'b0);
        cyc(1'b1, 1'b1, 8'd99, 1'b0);
        n_checks++; if (out_sum !== 10'd11) begin n_fail++; $display("FAIL restart_pre: got %0d expected 11", out_sum); end
        cyc(1'b0, 1'b1, 8'd1, 1'b0);
        n_checks++; if (out_sum !== 10'd0 || out_count !== 4'd0 || out_ready !== 1'b1) begin n_fail++; $display("FAIL restart_clear: got sum=%0d count=%0d ready=%b expected 0/0/1", out_sum, out_count, out_ready); end
        cyc(1'b0, 1'b1, 8'd2, 1'b0);
        cyc(1'b0, 1'b1, 8'd3, 1'b0);
        cyc(1'b0, 1'b1, 8'd4, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (out_sum !== 10'd10 || out_count !== 4'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL restart_result: got sum=%0d count=%0d valid=%b expected 10/4/1", out_sum, out_count, out_valid); end
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_hold();
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 8'd100, 1'b0);
        cyc(1'b0, 1'b1, 8'd1, 1'b0);
        cyc(1'b0, 1'b1, 8'd2, 1'b0);
        cyc(1'b0, 1'b1, 8'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) cyc(1'b0, 1'b1, 8'd50, 1'b0);
            else       cyc(1'b0, 1'b0, 8'd0, 1'b0);
            n_checks++; if (out_sum !== 10'd106 || out_count !== 4'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_%0d: got sum=%0d count=%0d valid=%b expected 106/4/1", i, out_sum, out_count, out_valid); end
        end
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (out_sum !== 10'd0 || out_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_restart: got sum=%0d ready=%b valid=%b expected 0/1/0", out_sum, out_ready, out_valid); end
    endtask

    task automatic test_count1();
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 8'd55, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (sum1 !== 10'd55 || count1 !== 4'd1 || valid1 !== 1'b1) begin n_fail++; $display("FAIL count1: got sum=%0d count=%0d valid=%b expected 55/1/1", sum1, count1, valid1); end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 8'd7, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (out_sum !== 10'd7) begin n_fail++; $display("FAIL areset_pre: got %0d expected 7", out_sum); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({out_ready, out_valid, out_overflow, out_count, out_sum} !== 17'd0) begin n_fail++; $display("FAIL areset_clear: got ready=%b valid=%b ovf=%b count=%0d sum=%0d expected all 0", out_ready, out_valid, out_overflow, out_count, out_sum); end
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, 8'd9, 1'b0);
        cyc(1'b0, 1'b1, 8'd9, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if ({out_ready, out_count, out_sum} !== 15'd0) begin n_fail++; $display("FAIL areset_ignore: got ready=%b count=%0d sum=%0d expected 0/0/0", out_ready, out_count, out_sum); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_overflow();
        test_restart();
        test_hold();
        test_count1();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lab4_prod_accum.md
Name: lab4_prod_accum

Overview:
- Sequential stage directly downstream of the 5x3 binary multiplier.
- Consumes the multiplier's 8-bit product, one product per accepted handshake, and accumulates COUNT products into a wider running sum.
- Presents the final sum with a valid/ack handshake, so the combinational multiplier can be time-shared to form a dot product of COUNT 5x3 terms.

Parameters:
- COUNT, 4, number of products accumulated per block; legal range 1..15.
- ACC_W, 10, accumulator width in bits; legal range 8..16. The default holds 4*217=868 without overflow.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_start  input  1  begin a new accumulation block; clears the sum.
- in_valid  input  1  in_m carries a valid product this cycle.
- in_m  input  8  unsigned product from the multiplier.
- in_ack  input  1  consumer has taken out_sum.
- out_ready  output  1  block accepts products this cycle.
- out_sum  output  ACC_W  accumulator register.
- out_valid  output  1  out_sum holds a completed block result.
- out_overflow  output  1  sticky; set if any addition in this block carried out of ACC_W.
- out_count  output  4  number of products accepted in the current block.

Behaviour:
- Reset (asynchronous, immediate, any state, mid-block included):
  - state=IDLE, out_sum=0, out_count=0, out_valid=0, out_overflow=0, out_ready=0.
  - No partial result survives.
- States: IDLE, ACCUM, HOLD. Outputs are registered or decoded from state only; there is no combinational path from in_* to out_*.
- out_ready=1 only in ACCUM. out_valid=1 only in HOLD.
- IDLE:
  - in_valid and in_ack are ignored.
  - in_start=1 at an edge: out_sum=0, out_count=0, out_overflow=0, next state ACCUM.
- ACCUM:
  - A product is accepted on an edge where in_valid=1 and in_start=0.
  - On accept: out_sum <= out_sum + zero-extend(in_m), computed ACC_W+1 wide.
  - The carry bit ORs into out_overflow; the stored sum wraps modulo 2^ACC_W.
  - out_count increments on each accept.
  - Bubbles (in_valid=0) hold all state, with no limit on their length.
  - When the accepted product is the COUNT-th, the next state is HOLD. The final sum is visible in HOLD's first cycle; latency from the last accept edge to out_valid=1 is 1 cycle.
  - in_start=1 in ACCUM restarts the block (clear, stay ACCUM). start has priority: a coincident in_valid product is discarded, not counted.
- HOLD:
  - out_sum, out_count and out_overflow are frozen. in_valid is ignored.
  - in_ack=1 with in_start=0: next state IDLE and out_valid falls. out_sum stays readable until the next start.
  - in_start=1, with or without in_ack: treated as ack plus restart; clear, next state ACCUM, no IDLE cycle.
  - out_valid is held indefinitely until in_ack or in_start.
- COUNT=1: a single accept moves ACCUM to HOLD.
- in_m is unsigned 0..255. The multiplier's maximum legitimate value is 217, but the full range is accepted.

Optional Feature:
- Macro: LAB4_ACC_SATURATE_EN.
- Defined: on carry-out, out_sum clamps to 2^ACC_W-1 and stays there for the rest of the block; out_overflow is still set.
- Undefined: wrap-around modulo 2^ACC_W as described above.
- Handshake and timing are identical in both builds.

Test Plan:
1. Default params. Reset, start, then four products of 217 back-to-back -> out_sum=868, out_count=4, out_overflow=0, out_valid=1 exactly one cycle after the 4th accept. Ack -> IDLE, out_valid=0.
2. Products 10, 20, 30, 40 with 2-cycle bubbles between them -> out_sum=100, out_valid only after the 4th accept, and no change during bubbles.
3. ACC_W=8, four products of 217 -> wrap build: out_sum=100, out_overflow=1. LAB4_ACC_SATURATE_EN build: out_sum=255, out_overflow=1.
4. After 2 products (5, 6), in_start and in_valid(99) coincide, then products 1, 2, 3, 4 -> out_sum=10, out_count=4 (the 99 is discarded).
5. In HOLD, withhold in_ack for 5 cycles while driving in_valid=1, in_m=50 -> out_sum, out_count and out_valid stay stable. Then in_start in HOLD -> ACCUM next cycle with out_sum=0.
6. Assert reset asynchronously between clock edges mid-ACCUM -> all outputs 0 before the next edge. in_valid after reset release with no start -> ignored.
